bt_packet_parser: RTL and testbench

//  Downstream consumer of bluetooth_rx. Takes its byte strobes (data_out / finished_receiving),

---
 rtl/bt_packet_parser.sv | 234 +++++++++++++++++++++++
 tb/tb_bt_packet_parser.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_packet_parser.sv
// Framed-packet parser for the Bluetooth UART byte stream: SYNC, LEN, payload, XOR checksum.
// Payload is buffered and released on a valid/ready stream only after the checksum matches.
module bt_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 26040
) (
  input  logic       clk,
  input  logic       rst_n_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [5:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop
);

  localparam int unsigned LW = 6;
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  // Reset asserts asynchronously and releases two clocks later, in step with clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   rd_q, rd_d;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [LW-1:0]   frame_len_q, frame_len_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            drop_q, drop_d;

  logic            buf_we_c;
  logic            in_frame_c;
  logic [LW-1:0]   rd_next_c;
  logic [7:0]      buf_mem [MAX_LEN];

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_c) begin
      buf_mem[idx_q[AW-1:0]] <= byte_in;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_len_d = frame_len_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;
    buf_we_c    = 1'b0;
    rd_next_c   = rd_q + LW'(1);
    in_frame_c  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

    // Inter-byte watchdog, only while a frame is partially received.
    if (in_frame_c && !byte_valid_in) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (byte_valid_in) begin
          if ((byte_in == 8'd0) || (byte_in > 8'(MAX_LEN))) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d   = byte_in[LW-1:0];
            csum_d  = byte_in;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (byte_valid_in) begin
          buf_we_c = 1'b1;
          csum_d   = csum_q ^ byte_in;
          idx_d    = idx_q + LW'(1);
          if (idx_q == (len_q - LW'(1))) begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (byte_valid_in) begin
          if (byte_in == csum_q) begin
            frame_ok_d  = 1'b1;
            frame_len_d = len_q;
            rd_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = buf_mem[0];
            out_last_d  = (len_q == LW'(1));
            state_d     = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (byte_valid_in) begin
          drop_d = 1'b1;
        end
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rd_d       = rd_next_c;
            out_data_d = buf_mem[rd_next_c[AW-1:0]];
            out_last_d = (rd_next_c == (len_q - LW'(1)));
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_len_q <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_len_q <= frame_len_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_len = frame_len_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_bt_packet_parser.sv
// Scoreboard bench for bt_packet_parser: stimulus pushes expected bytes/pulses, a monitor pops and compares.
module tb_bt_packet_parser;

  localparam int unsigned TIMEOUT = 26040;

  logic       clk = 1'b0;
  logic       rst_n_in;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [5:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       drop;

  always #5 clk = ~clk;

  bt_packet_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (32),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n_in      (rst_n_in),
    .byte_in       (byte_in),
    .byte_valid_in (byte_valid_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .frame_len     (frame_len),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .drop          (drop)
  );

  typedef struct {
    logic [1:0] kind;  // 0=frame_ok, 1=frame_err, 2=drop
    logic [7:0] val;   // frame_len for ok, err_code for err
  } evt_t;

  evt_t       exp_evt[$];
  logic [8:0] exp_out[$];   // {last, data}
  logic [7:0] tx[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h expected nothing at %0t", name, act, $time);
  endtask

  task automatic push_evt(input logic [1:0] kind, input logic [7:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    exp_evt.push_back(e);
  endtask

  task automatic push_out(input logic [7:0] d, input logic last);
    exp_out.push_back({last, d});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte strobe per cycle; returns just after the edge that sampled the final byte.
  task automatic send_tx();
    foreach (tx[i]) begin
      byte_in       = tx[i];
      byte_valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid_in = 1'b0;
    byte_in       = 8'h00;
  endtask

  function automatic logic [31:0] outs_packed();
    return 32'({out_data, out_valid, out_last, frame_len, frame_ok, frame_err, err_code, drop});
  endfunction

  // Asserted between clock edges so the monitor never races the queue flush.
  task automatic mid_reset(input string name);
    @(posedge clk);
    #2;
    rst_n_in = 1'b0;
    exp_out.delete();
    #1;
    check(name, outs_packed(), 32'd0);
    tick(2);
    rst_n_in = 1'b1;
    tick(4);
  endtask

  // Monitor: compares every handshake and every pulse against the scoreboard.
  always @(negedge clk) begin
    logic [8:0] e;
    evt_t       ev;
    logic [1:0] k;
    if (rst_n_in) begin
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          note_fail("out_unexpected", 32'(out_data));
        end else if (out_ready) begin
          e = exp_out.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_last", 32'(out_last), 32'(e[8]));
        end else begin
          e = exp_out[0];
          check("stall_hold", 32'(out_data), 32'(e[7:0]));
        end
      end
      if (frame_ok || frame_err || drop) begin
        check("pulse_exclusive", 32'(frame_ok) + 32'(frame_err) + 32'(drop), 32'd1);
        k = frame_ok ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
        if (exp_evt.size() == 0) begin
          note_fail("evt_unexpected", 32'(k));
        end else begin
          ev = exp_evt.pop_front();
          check("evt_kind", 32'(k), 32'(ev.kind));
          if (k == 2'd0) check("frame_len", 32'(frame_len), 32'(ev.val));
          else if (k == 2'd1) check("err_code", 32'(err_code), 32'(ev.val));
        end
      end
    end
  end

  initial begin
    logic rdy_pat [5];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n_in      = 1'b1;
    byte_in       = 8'h00;
    byte_valid_in = 1'b0;
    out_ready     = 1'b1;
    #3;
    rst_n_in = 1'b0;
    #1;
    check("reset_outputs", outs_packed(), 32'd0);
    tick(3);
    rst_n_in = 1'b1;
    tick(4);
    check("post_reset_outputs", outs_packed(), 32'd0);

    // Good frame, full throughput drain
    push_evt(2'd0, 8'd3);
    push_out(8'h11, 1'b0);
    push_out(8'h22, 1'b0);
    push_out(8'h33, 1'b1);
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_tx();
    @(negedge clk);
    check("t1_ok_latency", 32'(frame_ok), 32'd1);
    check("t1_valid_c0", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_c1", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_c2", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_end", 32'(out_valid), 32'd0);
    tick(2);

    // Bad checksum, then a good frame
    push_evt(2'd1, 8'd2);
    tx = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_tx();
    tick(3);
    check("t2_no_valid", 32'(out_valid), 32'd0);
    check("t2_err_hold", 32'(err_code), 32'd2);
    check("t2_len_hold", 32'(frame_len), 32'd3);
    push_evt(2'd0, 8'd1);
    push_out(8'h5A, 1'b1);
    tx = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_tx();
    tick(4);

    // Bad lengths; trailing junk ignored until SYNC
    push_evt(2'd1, 8'd1);
    push_evt(2'd1, 8'd1);
    tx = '{8'hA5, 8'h00, 8'hA5, 8'h21, 8'h11, 8'h22};
    send_tx();
    tick(3);
    check("t3_err_code", 32'(err_code), 32'd1);
    push_evt(2'd0, 8'd2);
    push_out(8'hC3, 1'b0);
    push_out(8'h3C, 1'b1);
    tx = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    send_tx();
    tick(4);

    // Backpressure with a byte dropped mid-drain
    push_evt(2'd0, 8'd3);
    push_out(8'h11, 1'b0);
    push_out(8'h22, 1'b0);
    push_out(8'h33, 1'b1);
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_tx();
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i];
      if (i == 1) begin
        push_evt(2'd2, 8'd0);
        byte_in       = 8'hA5;
        byte_valid_in = 1'b1;
      end
      @(posedge clk);
      #1;
      byte_valid_in = 1'b0;
    end
    out_ready = 1'b1;
    tick(2);
    check("t4_drained", 32'(out_valid), 32'd0);

    // Timeout: error must not arrive early, but must arrive near the limit
    tx = '{8'hA5, 8'h04, 8'h01};
    send_tx();
    tick(TIMEOUT - 50);
    check("t5_no_early_err", 32'(err_code), 32'd1);
    push_evt(2'd1, 8'd3);
    tick(100);
    check("t5_err_code", 32'(err_code), 32'd3);
    push_evt(2'd0, 8'd1);
    push_out(8'hA5, 1'b1);
    tx = '{8'hA5, 8'h01, 8'hA5, 8'hA4};
    send_tx();
    tick(4);

    // Reset mid-payload
    tx = '{8'hA5, 8'h05, 8'h01, 8'h02};
    send_tx();
    mid_reset("t6_rst_payload");
    push_evt(2'd0, 8'd1);
    push_out(8'h7E, 1'b1);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_tx();
    tick(4);

    // Reset mid-drain while stalled
    out_ready = 1'b0;
    push_evt(2'd0, 8'd2);
    push_out(8'h10, 1'b0);
    push_out(8'h20, 1'b1);
    tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    send_tx();
    tick(2);
    check("t6_stalled_valid", 32'(out_valid), 32'd1);
    mid_reset("t6_rst_drain");
    out_ready = 1'b1;
    push_evt(2'd0, 8'd1);
    push_out(8'h7E, 1'b1);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_tx();
    tick(6);

    check("final_out_queue", 32'(exp_out.size()), 32'd0);
    check("final_evt_queue", 32'(exp_evt.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
